key_move_ctrl: RTL and testbench

Converts the PS/2 scan-code byte stream into a frame-synchronous, bounds-clamped on-screen box position (oX, oY) for the VGA pixel pipeline. It sits directly upstream of the VGA controller and replaces its free-running counter/key-case logic. Position updates happen only at the start of vertical sync, so the picture never tears mid-frame. Held arrow keys auto-repeat.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/ps2_arrow_decoder.sv | 56 +++++
 rtl/key_move_ctrl.sv | 113 +++++++++++
 tb/tb_key_move_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA-side definitions: PS/2 arrow scan codes, parser states and
// saturating position helpers used by the box-move controller.
package vga_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [1:0] K_UP    = 2'd0;
    localparam logic [1:0] K_DOWN  = 2'd1;
    localparam logic [1:0] K_LEFT  = 2'd2;
    localparam logic [1:0] K_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } ps2_state_t;

    // {valid, key index}; valid is 0 for anything that is not an arrow
    function automatic logic [2:0] arrow_decode(input logic [7:0] code);
        case (code)
            SC_UP:    return {1'b1, K_UP};
            SC_DOWN:  return {1'b1, K_DOWN};
            SC_LEFT:  return {1'b1, K_LEFT};
            SC_RIGHT: return {1'b1, K_RIGHT};
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic [9:0] sat_dec(input logic [9:0] v, input logic [9:0] step);
        return (v < step) ? 10'd0 : v - step;
    endfunction

    // the sum is formed in 11 bits so a step near the top never wraps
    function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [9:0] step,
                                          input logic [9:0] max);
        logic [10:0] sum;
        sum = {1'b0, v} + {1'b0, step};
        return (sum > {1'b0, max}) ? max : sum[9:0];
    endfunction

endpackage

// File: rtl/ps2_arrow_decoder.sv
// PS/2 byte-stream parser: turns E0/F0-prefixed arrow codes into make/break
// strobes with a 2-bit key index, valid in the same cycle as key_en.
module ps2_arrow_decoder
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_in,
    input  logic       key_en,
    output logic       make_stb,
    output logic       brk_stb,
    output logic [1:0] key_idx
);

    ps2_state_t state_reg, state_next;
    logic [2:0] hit;

    assign hit     = arrow_decode(key_in);
    assign key_idx = hit[1:0];

    // strobes are decoded from the byte in hand so held/pend update on the
    // same edge that consumes the byte
    always_comb begin
        state_next = state_reg;
        make_stb   = 1'b0;
        brk_stb    = 1'b0;
        if (key_en) begin
            case (state_reg)
                PS_IDLE: begin
                    if (key_in == SC_E0)      state_next = PS_EXT;
                    else if (key_in == SC_F0) state_next = PS_BRK;
                    else                      make_stb   = hit[2];
                end
                PS_EXT: begin
                    if (key_in == SC_F0) begin
                        state_next = PS_EXT_BRK;
                    end else begin
                        state_next = PS_IDLE;
                        make_stb   = hit[2];
                    end
                end
                PS_BRK, PS_EXT_BRK: begin
                    state_next = PS_IDLE;
                    brk_stb    = hit[2];
                end
                default: state_next = PS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= PS_IDLE;
        else        state_reg <= state_next;
    end

endmodule

// File: rtl/key_move_ctrl.sv
// Arrow-key box mover: tracks held/pending keys, auto-repeats, and moves a
// clamped box position once per frame on the vsync falling edge.
module key_move_ctrl
    import vga_pkg::*;
#(
    parameter int STEP          = 10,
    parameter int BOX_W         = 64,
    parameter int BOX_H         = 48,
    parameter int H_ACT         = H_ACT_DEF,
    parameter int V_ACT         = V_ACT_DEF,
    parameter int X_INIT        = 320,
    parameter int Y_INIT        = 240,
    parameter int REPEAT_FRAMES = 6
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic [7:0] key_in,
    input  logic       key_en,
    input  logic       iVS,
    output logic [9:0] oX,
    output logic [9:0] oY,
    output logic       oMoved
);

    localparam int         REP_W    = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
    localparam logic [9:0] STEP_V   = 10'(STEP);
    localparam logic [9:0] MAX_X    = 10'(H_ACT - BOX_W - 1);
    localparam logic [9:0] MAX_Y    = 10'(V_ACT - BOX_H - 1);

    logic             make_stb, brk_stb;
    logic [1:0]       key_idx;
    logic             vs_d_reg, tick_reg;
    logic [3:0]       held_reg, held_next, pend_reg, pend_next, req, press;
    logic [REP_W-1:0] rep_reg, rep_next;
    logic             rep_wrap;
    logic [9:0]       x_reg, y_reg, x_next, y_next;
    logic             moved_reg;

    ps2_arrow_decoder u_dec (
        .clk      (iVGA_CLK),
        .rst_n    (iRST_n),
        .key_in   (key_in),
        .key_en   (key_en),
        .make_stb (make_stb),
        .brk_stb  (brk_stb),
        .key_idx  (key_idx)
    );

    assign rep_wrap = (rep_reg == REP_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic sel;
            assign sel           = (key_idx == 2'(gi));
            assign req[gi]       = pend_reg[gi] | (held_reg[gi] & rep_wrap);
            assign press[gi]     = make_stb & sel & ~held_reg[gi];
            assign held_next[gi] = (make_stb & sel) ? 1'b1 :
                                   (brk_stb & sel)  ? 1'b0 : held_reg[gi];
            // a press landing on the tick edge survives the clear
            assign pend_next[gi] = press[gi] | (pend_reg[gi] & ~tick_reg);
        end
    endgenerate

    // a frame that consumes a fresh press restarts the repeat period, so the
    // first auto-repeat comes a full REPEAT_FRAMES after the initial step
    always_comb begin
        rep_next = rep_reg;
        if ((|press) || (held_next == 4'b0000))
            rep_next = '0;
        else if (tick_reg)
            rep_next = ((|pend_reg) || rep_wrap) ? '0 : REP_W'(rep_reg + 1'b1);
    end

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (tick_reg) begin
            if (req[K_LEFT] & ~req[K_RIGHT]) x_next = sat_dec(x_reg, STEP_V);
            if (req[K_RIGHT] & ~req[K_LEFT]) x_next = sat_inc(x_reg, STEP_V, MAX_X);
            if (req[K_UP] & ~req[K_DOWN])    y_next = sat_dec(y_reg, STEP_V);
            if (req[K_DOWN] & ~req[K_UP])    y_next = sat_inc(y_reg, STEP_V, MAX_Y);
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_d_reg  <= 1'b1;
            tick_reg  <= 1'b0;
            held_reg  <= '0;
            pend_reg  <= '0;
            rep_reg   <= '0;
            x_reg     <= 10'(X_INIT);
            y_reg     <= 10'(Y_INIT);
            moved_reg <= 1'b0;
        end else begin
            vs_d_reg  <= iVS;
            tick_reg  <= vs_d_reg & ~iVS;
            held_reg  <= held_next;
            pend_reg  <= pend_next;
            rep_reg   <= rep_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            moved_reg <= (x_next != x_reg) || (y_next != y_reg);
        end
    end

    assign oX     = x_reg;
    assign oY     = y_reg;
    assign oMoved = moved_reg;

endmodule

// File: tb/tb_key_move_ctrl.sv
// Directed bench for key_move_ctrl: a frame-level model checked every cycle,
// plus hand-computed position/pulse expectations for each scenario.
module tb_key_move_ctrl;

    localparam int STEP  = 10;
    localparam int RF    = 6;
    localparam int MAX_X = 575;
    localparam int MAX_Y = 431;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       key_en = 1'b0;
    logic       vs = 1'b1;
    logic [9:0] ox, oy;
    logic       omoved;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    key_move_ctrl dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .key_in   (key_in),
        .key_en   (key_en),
        .iVS      (vs),
        .oX       (ox),
        .oY       (oy),
        .oMoved   (omoved)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_x = 320, m_y = 240, m_rep = 0, m_ps = 0;
    bit m_moved = 0, m_tick = 0, m_vs = 1;
    bit [3:0] m_held = 0, m_pend = 0;

    function automatic int arrow_of(input logic [7:0] c);
        case (c)
            8'h75:   return 0;
            8'h72:   return 1;
            8'h6B:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_x = 320; m_y = 240; m_rep = 0; m_ps = 0;
        m_moved = 0; m_tick = 0; m_vs = 1; m_held = 0; m_pend = 0;
    endtask

    task automatic model_step();
        bit [3:0] rq, nheld, npend;
        bit mk, bk, fresh;
        int k, nx, ny, nrep;
        m_moved = 0;
        if (m_tick) begin
            for (int i = 0; i < 4; i++) rq[i] = m_pend[i] || (m_held[i] && m_rep == RF - 1);
            nx = m_x; ny = m_y;
            if (rq[2] && !rq[3]) nx = (m_x < STEP) ? 0 : m_x - STEP;
            if (rq[3] && !rq[2]) nx = (m_x + STEP > MAX_X) ? MAX_X : m_x + STEP;
            if (rq[0] && !rq[1]) ny = (m_y < STEP) ? 0 : m_y - STEP;
            if (rq[1] && !rq[0]) ny = (m_y + STEP > MAX_Y) ? MAX_Y : m_y + STEP;
            m_moved = (nx != m_x) || (ny != m_y);
            m_x = nx; m_y = ny;
        end
        mk = 0; bk = 0;
        k = arrow_of(key_in);
        if (key_en) begin
            if (m_ps == 0) begin
                if (key_in == 8'hE0) m_ps = 1;
                else if (key_in == 8'hF0) m_ps = 2;
                else mk = (k >= 0);
            end else if (m_ps == 1) begin
                if (key_in == 8'hF0) m_ps = 2;
                else begin m_ps = 0; mk = (k >= 0); end
            end else begin
                m_ps = 0; bk = (k >= 0);
            end
        end
        nheld = m_held;
        npend = m_tick ? 4'b0 : m_pend;
        fresh = 0;
        if (mk) begin
            if (!m_held[k]) begin npend[k] = 1; fresh = 1; end
            nheld[k] = 1;
        end
        if (bk) nheld[k] = 0;
        if (fresh || nheld == 0) nrep = 0;
        else if (m_tick) nrep = (m_pend != 0 || m_rep == RF - 1) ? 0 : m_rep + 1;
        else nrep = m_rep;
        m_held = nheld; m_pend = npend; m_rep = nrep;
        m_tick = m_vs && !vs;
        m_vs = vs;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("model_x", int'(ox), m_x);
                check("model_y", int'(oy), m_y);
                check("model_moved", int'(omoved), int'(m_moved));
                if (omoved === 1'b1) pulse_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        key_in = b; key_en = 1'b1;
        cyc();
        key_en = 1'b0;
        cyc();
    endtask

    task automatic frame(input int low_cycles);
        vs = 1'b0;
        repeat (low_cycles) cyc();
        vs = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0; key_en = 1'b0; vs = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic tap(input logic [7:0] code);
        send(code); send(8'hF0); send(code);
        frame(3);
    endtask

    int p0;

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("reset_x", int'(ox), 320);
        check("reset_y", int'(oy), 240);
        check("reset_moved", int'(omoved), 0);

        // extended right make then one frame
        p0 = pulse_cnt;
        send(8'hE0); send(8'h74);
        frame(3);
        check("ext_right_x", int'(ox), 330);
        check("ext_right_pulse", pulse_cnt - p0, 1);
        send(8'hE0); send(8'hF0); send(8'h74);

        // tap within one frame, then idle frames incl. a long vsync low
        do_reset();
        p0 = pulse_cnt;
        send(8'h6B); send(8'hF0); send(8'h6B);
        frame(40);
        check("tap_x", int'(ox), 310);
        check("tap_pulse", pulse_cnt - p0, 1);
        for (int i = 0; i < 10; i++) frame(3);
        check("tap_idle_x", int'(ox), 310);
        check("tap_idle_pulse", pulse_cnt - p0, 1);

        // hold up: steps at frames 1, 7, 13; typematic makes ignored
        do_reset();
        send(8'h75);
        for (int f = 1; f <= 13; f++) begin
            frame(3);
            send(8'h75);
            if (f == 1)  check("hold_f1_y", int'(oy), 230);
            if (f == 6)  check("hold_f6_y", int'(oy), 230);
            if (f == 7)  check("hold_f7_y", int'(oy), 220);
            if (f == 13) check("hold_f13_y", int'(oy), 210);
        end
        send(8'hF0); send(8'h75);

        // right wall then left wall with saturation
        do_reset();
        for (int i = 0; i < 25; i++) tap(8'h74);
        check("walk_right_x", int'(ox), 570);
        p0 = pulse_cnt;
        tap(8'h74);
        check("right_clamp_x", int'(ox), 575);
        check("right_clamp_pulse", pulse_cnt - p0, 1);
        p0 = pulse_cnt;
        tap(8'h74);
        check("right_wall_x", int'(ox), 575);
        check("right_wall_pulse", pulse_cnt - p0, 0);
        for (int i = 0; i < 57; i++) tap(8'h6B);
        check("walk_left_x", int'(ox), 5);
        p0 = pulse_cnt;
        tap(8'h6B);
        check("left_clamp_x", int'(ox), 0);
        check("left_clamp_pulse", pulse_cnt - p0, 1);
        p0 = pulse_cnt;
        tap(8'h6B);
        check("left_wall_x", int'(ox), 0);
        check("left_wall_pulse", pulse_cnt - p0, 0);

        // opposing keys cancel; diagonal moves both axes in one pulse
        do_reset();
        p0 = pulse_cnt;
        send(8'h6B); send(8'h74);
        frame(3);
        check("lr_cancel_x", int'(ox), 320);
        check("lr_cancel_pulse", pulse_cnt - p0, 0);
        send(8'hF0); send(8'h6B); send(8'hF0); send(8'h74);
        p0 = pulse_cnt;
        send(8'h75); send(8'h74);
        frame(3);
        check("diag_x", int'(ox), 330);
        check("diag_y", int'(oy), 230);
        check("diag_pulse", pulse_cnt - p0, 1);
        send(8'hF0); send(8'h75); send(8'hF0); send(8'h74);

        // make in the tick cycle moves on the following frame
        do_reset();
        vs = 1'b0;
        cyc();
        key_in = 8'h74; key_en = 1'b1;
        cyc();
        key_en = 1'b0;
        cyc();
        vs = 1'b1;
        repeat (4) cyc();
        check("tickmake_f0_x", int'(ox), 320);
        send(8'hF0); send(8'h74);
        frame(3);
        check("tickmake_f1_x", int'(ox), 330);

        // reset between prefix and next byte discards the prefix
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h74);
        frame(3);
        check("rst_prefix_x", int'(ox), 330);

        // reset mid-hold clears held and position
        do_reset();
        send(8'h75);
        frame(3);
        check("midhold_y", int'(oy), 230);
        do_reset();
        check("midhold_rst_y", int'(oy), 240);
        check("midhold_rst_x", int'(ox), 320);
        for (int i = 0; i < 7; i++) frame(3);
        check("midhold_after_y", int'(oy), 240);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
